// File: rtl/jac1_pkg.sv
// Shared widths, port indices and FSM state type for the jac1 memory arbiter.
package jac1_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ADDR_WIDTH_DEF = 8;

   localparam int PORT_A = 0;
   localparam int PORT_B = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/jac1_rr_pick.sv
// Two-port round-robin winner selection; on a tie the port that did not win last is picked.
module jac1_rr_pick
   import jac1_pkg::*;
(
   input  logic       a_req,
   input  logic       b_req,
   input  logic       last_b,
   output logic [1:0] pick
);

   always_comb begin
      pick = 2'b00;
      if (a_req && (!b_req || last_b)) begin
         pick[PORT_A] = 1'b1;
      end else if (b_req) begin
         pick[PORT_B] = 1'b1;
      end
   end

endmodule

// File: rtl/jac1_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between CPU port A and loader port B.
// Define JAC1_ARB_STATS_EN to add the saturating conflict_cnt output.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate on any request
// ACCESS | grant pulse, RAM enabled with the winner's registered command
// RESP   | read data returned to winner; arbitrate again for back-to-back access
module jac1_mem_arbiter
   import jac1_pkg::*;
#(
   parameter int DataWidth = DATA_WIDTH_DEF,
   parameter int AddrWidth = ADDR_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 sys_res_n,
   input  logic                 a_req,
   input  logic                 a_we,
   input  logic [AddrWidth-1:0] a_addr,
   input  logic [DataWidth-1:0] a_wdata,
   output logic                 a_gnt,
   output logic                 a_rvalid,
   output logic [DataWidth-1:0] a_rdata,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic [AddrWidth-1:0] b_addr,
   input  logic [DataWidth-1:0] b_wdata,
   output logic                 b_gnt,
   output logic                 b_rvalid,
   output logic [DataWidth-1:0] b_rdata,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [AddrWidth-1:0] mem_addr,
   output logic [DataWidth-1:0] mem_wdata,
   input  logic [DataWidth-1:0] mem_rdata
`ifdef JAC1_ARB_STATS_EN
   ,
   output logic [7:0]           conflict_cnt
`endif
);

   arb_state_t state;
   logic       last_b;
   logic [1:0] pick;

   jac1_rr_pick u_rr_pick (
      .a_req  (a_req),
      .b_req  (b_req),
      .last_b (last_b),
      .pick   (pick)
   );

   // The RAM output is only meaningful in RESP, so it is gated rather than re-registered.
   assign a_rdata = a_rvalid ? mem_rdata : '0;
   assign b_rdata = b_rvalid ? mem_rdata : '0;

   always_ff @(posedge clk or negedge sys_res_n) begin
      if (!sys_res_n) begin
         state     <= IDLE;
         last_b    <= 1'b1;
         a_gnt     <= 1'b0;
         b_gnt     <= 1'b0;
         a_rvalid  <= 1'b0;
         b_rvalid  <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         a_gnt     <= 1'b0;
         b_gnt     <= 1'b0;
         a_rvalid  <= 1'b0;
         b_rvalid  <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         case (state)
            IDLE, RESP: begin
               if (pick[PORT_A] || pick[PORT_B]) begin
                  state     <= ACCESS;
                  last_b    <= pick[PORT_B];
                  a_gnt     <= pick[PORT_A];
                  b_gnt     <= pick[PORT_B];
                  mem_en    <= 1'b1;
                  mem_we    <= pick[PORT_B] ? b_we    : a_we;
                  mem_addr  <= pick[PORT_B] ? b_addr  : a_addr;
                  mem_wdata <= pick[PORT_B] ? b_wdata : a_wdata;
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               state    <= RESP;
               a_rvalid <= !mem_we && !last_b;
               b_rvalid <= !mem_we &&  last_b;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef JAC1_ARB_STATS_EN
   logic arb_point;

   assign arb_point = (state == IDLE) || (state == RESP);

   always_ff @(posedge clk or negedge sys_res_n) begin
      if (!sys_res_n) begin
         conflict_cnt <= '0;
      end else if (arb_point && a_req && b_req && (conflict_cnt != 8'hFF)) begin
         conflict_cnt <= conflict_cnt + 8'd1;
      end
   end
`endif

endmodule
